// File: rtl/apb4_pkg.sv
// Shared types and sizing helpers for the APB4 completer memory slice.
package apb4_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

    // Request attributes captured in the setup cycle and held through the access phase.
    typedef struct packed {
        logic write;
        logic err;
    } apb_req_t;

    function automatic int unsigned align_of(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb4_byte_mem.sv
// Word-organised memory with per-byte write enables and a registered read port.
module apb4_byte_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned IDX_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    re,
    input  logic                    rclr,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata
);

    localparam int unsigned NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rclr) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/apb4_slave_mem.sv
// APB4 completer: byte-lane memory with runtime wait states, PSLVERR checks and
// a saturating error counter.
module apb4_slave_mem
    import apb4_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned WAIT_W     = 4,
    parameter int unsigned PRIV_BASE  = DEPTH,
    parameter int unsigned ERRCNT_W   = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    input  logic [WAIT_W-1:0]       wait_cfg,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [ERRCNT_W-1:0]     err_cnt
);

    localparam int unsigned ALIGN = align_of(DATA_WIDTH);
    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam int unsigned NB    = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PRIV_A     = ADDR_WIDTH'(PRIV_BASE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN) - 1);

    apb_state_e            state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    apb_req_t              req_q, req_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic [ADDR_WIDTH-1:0] word;
    logic                  setup_err;
    logic                  mem_re;
    logic                  mem_rclr;
    logic                  mem_we;
    logic                  unused_prot;

    assign unused_prot = ^pprot[2:1];

    assign word = paddr >> ALIGN;

    // PRIV_BASE == DEPTH leaves the privilege term unreachable, since any such
    // word already fails the range check.
    always_comb begin
        setup_err = 1'b0;
        if (word >= DEPTH_A)                      setup_err = 1'b1;
        if ((paddr & ALIGN_MASK) != '0)           setup_err = 1'b1;
        if (!pwrite && (pstrb != '0))             setup_err = 1'b1;
        if ((word >= PRIV_A) && !pprot[0])        setup_err = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_cnt_d = err_cnt_q;
        mem_re    = 1'b0;
        mem_rclr  = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    req_d.write = pwrite;
                    req_d.err   = setup_err;
                    idx_d       = word[IDX_W-1:0];
                    wdata_d     = pwdata;
                    strb_d      = pstrb;
                    cnt_d       = wait_cfg;
                    mem_re      = !pwrite && !setup_err;
                    mem_rclr    = !pwrite && setup_err;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    state_d = IDLE;
                    mem_we  = req_q.write && !req_q.err && !preset;
                    if (req_q.err && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    apb4_byte_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (pclk),
        .rst   (preset),
        .re    (mem_re),
        .rclr  (mem_rclr),
        .raddr (word[IDX_W-1:0]),
        .rdata (prdata),
        .we    (mem_we),
        .wbe   (strb_q),
        .waddr (idx_q),
        .wdata (wdata_q)
    );

    assign pready  = (state_q == ACCESS) && (cnt_q == '0);
    assign pslverr = pready && req_q.err;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Directed bench for apb4_slave_mem: data, wait states, byte lanes, errors, aborts, reset.
module tb_apb4_slave_mem;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [3:0]  wait_cfg;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    apb4_slave_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (1024),
        .WAIT_W     (4),
        .PRIV_BASE  (512),
        .ERRCNT_W   (16)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .pprot    (pprot),
        .wait_cfg (wait_cfg),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .err_cnt  (err_cnt)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the completion edge.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdat,
                            input logic [3:0] strb, input logic [2:0] prot, input logic [3:0] wt,
                            output logic [31:0] rdat, output logic err, output int waits);
        bit done = 0;
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wdat;
        pstrb = strb; pprot = prot; wait_cfg = wt;
        @(posedge pclk); #1;
        penable = 1;
        waits = 0; rdat = '0; err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (pready) begin
                rdat = prdata; err = pslverr; done = 1;
                break;
            end
            waits++;
        end
        if (!done) check_eq("ready_timeout", 64'(done), 64'd1);
        @(posedge pclk); #1;
        psel = 0; penable = 0;
    endtask

    task automatic xfer_chk(input string tag, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdat, input logic [3:0] strb, input logic [2:0] prot,
                            input logic [3:0] wt, input bit exp_err, input bit chk_data,
                            input logic [31:0] exp_data);
        logic [31:0] rd;
        logic        er;
        int          w;
        apb_xfer(wr, addr, wdat, strb, prot, wt, rd, er, w);
        check_eq({tag, "_waits"}, 64'(w), 64'(wt));
        check_eq({tag, "_pslverr"}, 64'(er), 64'(exp_err));
        if (chk_data) check_eq({tag, "_prdata"}, 64'(rd), 64'(exp_data));
    endtask

    // Write with psel dropped after two waited ACCESS cycles.
    task automatic abort_write(input logic [31:0] addr, input logic [31:0] wdat);
        psel = 1; penable = 0; pwrite = 1; paddr = addr; pwdata = wdat;
        pstrb = 4'hF; pprot = 3'b000; wait_cfg = 4'd5;
        @(posedge pclk); #1;
        penable = 1;
        repeat (2) @(posedge pclk);
        #1;
        psel = 0; penable = 0;
        @(posedge pclk); #1;
    endtask

    initial begin
        preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        pstrb = '0; pprot = '0; wait_cfg = '0;
        repeat (3) @(posedge pclk);
        #1 preset = 0;
        @(negedge pclk);
        check_eq("rst_prdata", 64'(prdata), 64'd0);
        check_eq("rst_pready", 64'(pready), 64'd0);
        check_eq("rst_pslverr", 64'(pslverr), 64'd0);
        check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge pclk); #1;

        xfer_chk("w10", 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0, 0, 0, 32'h0);
        xfer_chk("r10", 0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, 0, 1, 32'hDEADBEEF);
        xfer_chk("r10_w3", 0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd3, 0, 1, 32'hDEADBEEF);

        xfer_chk("w20_full", 1, 32'h20, 32'h11223344, 4'hF, 3'b000, 4'd0, 0, 0, 32'h0);
        xfer_chk("w20_lanes", 1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, 4'd1, 0, 0, 32'h0);
        xfer_chk("r20_merge", 0, 32'h20, 32'h0, 4'h0, 3'b000, 4'd0, 0, 1, 32'h11BB33DD);

        xfer_chk("r_oob", 0, 32'h1000, 32'h0, 4'h0, 3'b000, 4'd0, 1, 1, 32'h0);
        check_eq("err_cnt_1", 64'(err_cnt), 64'd1);
        xfer_chk("w_misal", 1, 32'h22, 32'h55555555, 4'hF, 3'b000, 4'd0, 1, 0, 32'h0);
        check_eq("err_cnt_2", 64'(err_cnt), 64'd2);
        xfer_chk("r20_kept", 0, 32'h20, 32'h0, 4'h0, 3'b000, 4'd0, 0, 1, 32'h11BB33DD);
        xfer_chk("r_strb", 0, 32'h10, 32'h0, 4'h1, 3'b000, 4'd0, 1, 1, 32'h0);
        check_eq("err_cnt_3", 64'(err_cnt), 64'd3);

        xfer_chk("w600_priv", 1, 32'h960, 32'h12345678, 4'hF, 3'b001, 4'd0, 0, 0, 32'h0);
        xfer_chk("w600_user", 1, 32'h960, 32'hCAFEF00D, 4'hF, 3'b000, 4'd0, 1, 0, 32'h0);
        check_eq("err_cnt_4", 64'(err_cnt), 64'd4);
        xfer_chk("r600_kept", 0, 32'h960, 32'h0, 4'h0, 3'b001, 4'd0, 0, 1, 32'h12345678);
        xfer_chk("w600_priv2", 1, 32'h960, 32'hCAFEF00D, 4'hF, 3'b001, 4'd2, 0, 0, 32'h0);
        xfer_chk("r600_new", 0, 32'h960, 32'h0, 4'h0, 3'b001, 4'd0, 0, 1, 32'hCAFEF00D);
        xfer_chk("r600_user", 0, 32'h960, 32'h0, 4'h0, 3'b000, 4'd0, 1, 1, 32'h0);
        check_eq("err_cnt_5", 64'(err_cnt), 64'd5);

        xfer_chk("w10_nostrb", 1, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, 0, 0, 32'h0);
        xfer_chk("r10_nostrb", 0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, 0, 1, 32'hDEADBEEF);

        abort_write(32'h10, 32'h0);
        abort_write(32'h22, 32'h0);
        check_eq("abort_err_cnt", 64'(err_cnt), 64'd5);
        xfer_chk("r10_abort", 0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, 0, 1, 32'hDEADBEEF);

        // Reset lands on what would have been the completion edge of a write.
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h20; pwdata = 32'h0;
        pstrb = 4'hF; pprot = 3'b000; wait_cfg = 4'd0;
        @(posedge pclk); #1;
        penable = 1;
        @(negedge pclk);
        check_eq("pre_rst_pready", 64'(pready), 64'd1);
        preset = 1;
        @(posedge pclk); #1;
        preset = 0; psel = 0; penable = 0;
        @(negedge pclk);
        check_eq("midrst_pready", 64'(pready), 64'd0);
        check_eq("midrst_pslverr", 64'(pslverr), 64'd0);
        check_eq("midrst_prdata", 64'(prdata), 64'd0);
        check_eq("midrst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge pclk); #1;
        xfer_chk("r20_post_rst", 0, 32'h20, 32'h0, 4'h0, 3'b000, 4'd0, 0, 1, 32'h11BB33DD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
